alu_rr_sched: RTL and testbench



---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu_rr_sched_if.sv | 26 ++
 rtl/alu_core.sv | 32 +++
 rtl/alu_rr_sched.sv | 92 +++++++++
 tb/tb_alu_rr_sched.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes, widths and FSM state encoding for the round-robin ALU scheduler.
package alu_pkg;
   localparam int ALU_IN_W  = 4;
   localparam int ALU_OUT_W = 6;

   localparam logic [2:0] OP_PASS = 3'b000;
   localparam logic [2:0] OP_ADD  = 3'b001;
   localparam logic [2:0] OP_SUB  = 3'b010;
   localparam logic [2:0] OP_INC  = 3'b011;
   localparam logic [2:0] OP_DEC  = 3'b100;
   localparam logic [2:0] OP_MAX  = 3'b101;
   localparam logic [2:0] OP_MIN  = 3'b110;
   localparam logic [2:0] OP_AVG  = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_e;
endpackage

// File: rtl/alu_rr_sched_if.sv
// Requester command buses and tagged response port of the shared ALU scheduler.
interface alu_rr_sched_if #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
);
   import alu_pkg::*;

   logic [NREQ-1:0]                req_valid;
   logic [NREQ-1:0]                req_ready;
   logic [NREQ-1:0][2:0]           req_op;
   logic [NREQ-1:0][ALU_IN_W-1:0]  req_a;
   logic [NREQ-1:0][ALU_IN_W-1:0]  req_b;
   logic                           rsp_valid;
   logic                           rsp_ready;
   logic [ALU_OUT_W-1:0]           rsp_data;
   logic [IDW-1:0]                 rsp_id;

   modport master (
      output req_valid, req_op, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_id
   );
   modport slave (
      input  req_valid, req_op, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_id
   );
endinterface

// File: rtl/alu_core.sv
// Combinational 4-bit, 8-function ALU producing a 6-bit modulo-64 result.
module alu_core
   import alu_pkg::*;
(
   input  logic [2:0]           op,
   input  logic [ALU_IN_W-1:0]  a,
   input  logic [ALU_IN_W-1:0]  b,
   output logic [ALU_OUT_W-1:0] result
);
   logic [ALU_OUT_W-1:0] a_x, b_x;
   logic [ALU_IN_W:0]    sum_h;

   assign a_x   = ALU_OUT_W'(a);
   assign b_x   = ALU_OUT_W'(b);
   // Average keeps only the 5-bit sum before halving, so 15+15 averages to 15.
   assign sum_h = {1'b0, a} + {1'b0, b};

   always_comb begin
      result = a_x;
      case (op)
         OP_PASS: result = a_x;
         OP_ADD:  result = a_x + b_x;
         OP_SUB:  result = a_x - b_x;
         OP_INC:  result = a_x + ALU_OUT_W'(1);
         OP_DEC:  result = a_x - ALU_OUT_W'(1);
         OP_MAX:  result = (a >= b) ? a_x : b_x;
         OP_MIN:  result = (a <= b) ? a_x : b_x;
         OP_AVG:  result = ALU_OUT_W'(sum_h[ALU_IN_W:1]);
         default: result = a_x;
      endcase
   end
endmodule

// File: rtl/alu_rr_sched.sv
// Round-robin arbiter sharing one ALU among NREQ requesters; IDLE -> EXEC -> RESP per op.
module alu_rr_sched
   import alu_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   alu_rr_sched_if.slave bus,
   output logic          busy
);
   localparam logic [IDW:0]   NREQ_W = (IDW+1)'(NREQ);
   localparam logic [IDW-1:0] LAST   = IDW'(NREQ-1);

   state_e               state;
   logic [IDW-1:0]       rr_ptr, winner, id_q, rsp_id_q;
   logic [IDW:0]         idx;
   logic                 found;
   logic [2:0]           op_q;
   logic [ALU_IN_W-1:0]  a_q, b_q;
   logic [ALU_OUT_W-1:0] alu_res, rsp_data_q;
   logic                 rsp_valid_q;

   // First valid requester at or above rr_ptr, wrapping modulo NREQ.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      idx    = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = {1'b0, rr_ptr} + (IDW+1)'(k);
         if (idx >= NREQ_W) idx = idx - NREQ_W;
         if (!found && bus.req_valid[idx[IDW-1:0]]) begin
            found  = 1'b1;
            winner = idx[IDW-1:0];
         end
      end
   end

   always_comb begin
      bus.req_ready = '0;
      if (rst_n && state == ST_IDLE && found) bus.req_ready[winner] = 1'b1;
   end

   alu_core u_alu (
      .op     (op_q),
      .a      (a_q),
      .b      (b_q),
      .result (alu_res)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         rr_ptr      <= '0;
         op_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         id_q        <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_id_q    <= '0;
      end else begin
         case (state)
            ST_IDLE: if (found) begin
               op_q   <= bus.req_op[winner];
               a_q    <= bus.req_a[winner];
               b_q    <= bus.req_b[winner];
               id_q   <= winner;
               rr_ptr <= (winner == LAST) ? '0 : winner + IDW'(1);
               state  <= ST_EXEC;
            end
            ST_EXEC: begin
               rsp_data_q  <= alu_res;
               rsp_id_q    <= id_q;
               rsp_valid_q <= 1'b1;
               state       <= ST_RESP;
            end
            ST_RESP: if (bus.rsp_ready) begin
               rsp_valid_q <= 1'b0;
               state       <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_id    = rsp_id_q;
   assign busy          = (state != ST_IDLE);
endmodule

// File: tb/tb_alu_rr_sched.sv
// Scoreboard bench for alu_rr_sched: directed ops push expected {id,data}; a monitor pops on each handshake.
module tb_alu_rr_sched;
   import alu_pkg::*;
   localparam int NREQ = 4;
   localparam int IDW  = 2;

   logic clk = 1'b0;
   logic rst_n;
   logic busy;

   alu_rr_sched_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

   alu_rr_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave),
      .busy  (busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passes = 0;
   logic [7:0] exp_q[$];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
   endtask

   // Monitor: a response handshake completes on the posedge after this negedge.
   initial begin : mon
      logic [7:0] e;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && bus.rsp_valid && bus.rsp_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               $display("FAIL unexpected_rsp: got id %0d data %0d, expected no response", bus.rsp_id, bus.rsp_data);
            end else begin
               e = exp_q.pop_front();
               chk("rsp_id", int'(bus.rsp_id), int'(e[7:6]));
               chk("rsp_data", int'(bus.rsp_data), int'(e[5:0]));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_grant(output logic [NREQ-1:0] g);
      int t;
      t = 0;
      g = '0;
      while (g == '0 && t < 50) begin
         @(negedge clk);
         g = bus.req_ready;
         t++;
      end
      if (g == '0) begin
         checks++;
         $display("FAIL grant_timeout: got no grant, expected one within 50 cycles");
      end
      @(posedge clk);
      #1;
   endtask

   task automatic load(input int id, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
      bus.req_op[id] = op;
      bus.req_a[id]  = a;
      bus.req_b[id]  = b;
   endtask

   task automatic send(input int id, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                       input logic [5:0] exp, input bit push);
      logic [NREQ-1:0] g;
      load(id, op, a, b);
      if (push) exp_q.push_back({2'(id), exp});
      bus.req_valid[id] = 1'b1;
      wait_grant(g);
      chk("grant_sel", int'(g), 1 << id);
      bus.req_valid[id] = 1'b0;
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while (busy && t < 20) begin
         cyc(1);
         t++;
      end
      chk("idle_reached", int'(busy), 0);
   endtask

   initial begin
      logic [NREQ-1:0] g;
      logic [NREQ-1:0] gs[5];
      int order[5];
      int cnt;
      order = '{0, 1, 2, 3, 0};

      rst_n         = 1'b0;
      bus.req_valid = '1;
      bus.rsp_ready = 1'b0;
      bus.req_op    = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      #12;
      chk("reset_req_ready", int'(bus.req_ready), 0);
      chk("reset_rsp_valid", int'(bus.rsp_valid), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_rsp_data", int'(bus.rsp_data), 0);
      chk("reset_rsp_id", int'(bus.rsp_id), 0);
      bus.req_valid = '0;
      cyc(1);
      rst_n = 1'b1;
      cyc(1);

      // Single op, response held while rsp_ready is low
      send(0, OP_ADD, 4'd9, 4'd7, 6'd16, 1'b1);
      chk("exec_busy", int'(busy), 1);
      chk("exec_no_rsp", int'(bus.rsp_valid), 0);
      cyc(1);
      chk("lat_rsp_valid", int'(bus.rsp_valid), 1);
      chk("lat_rsp_data", int'(bus.rsp_data), 16);
      chk("lat_rsp_id", int'(bus.rsp_id), 0);
      cyc(3);
      chk("hold_rsp_valid", int'(bus.rsp_valid), 1);
      chk("hold_rsp_data", int'(bus.rsp_data), 16);
      bus.rsp_ready = 1'b1;
      cyc(1);
      chk("release_rsp_valid", int'(bus.rsp_valid), 0);
      chk("release_busy", int'(busy), 0);

      // Function table and wrap cases
      send(1, OP_SUB,  4'd2,  4'd5,  6'd61, 1'b1); wait_idle();
      send(2, OP_DEC,  4'd0,  4'd0,  6'd63, 1'b1); wait_idle();
      send(3, OP_AVG,  4'd15, 4'd15, 6'd15, 1'b1); wait_idle();
      send(0, OP_MAX,  4'd3,  4'd12, 6'd12, 1'b1); wait_idle();
      send(1, OP_MIN,  4'd3,  4'd12, 6'd3,  1'b1); wait_idle();
      send(2, OP_PASS, 4'd10, 4'd4,  6'd10, 1'b1); wait_idle();
      send(3, OP_INC,  4'd15, 4'd0,  6'd16, 1'b1); wait_idle();

      // Fairness: all valid, rr_ptr at 0
      for (int i = 0; i < NREQ; i++) load(i, OP_ADD, 4'(i), 4'd1);
      for (int k = 0; k < 5; k++) exp_q.push_back({2'(order[k]), 6'(order[k] + 1)});
      bus.req_valid = '1;
      for (int k = 0; k < 5; k++) wait_grant(gs[k]);
      bus.req_valid = '0;
      for (int k = 0; k < 5; k++) chk("rr_order", int'(gs[k]), 1 << order[k]);
      for (int i = 0; i < NREQ; i++) begin
         cnt = 0;
         for (int k = 0; k < 4; k++) if (gs[k][i]) cnt++;
         chk("rr_once_per_round", cnt, 1);
      end
      wait_idle();

      // Sparse: bring rr_ptr to 2, then only requesters 0 and 3 valid
      send(1, OP_PASS, 4'd5, 4'd0, 6'd5, 1'b1); wait_idle();
      load(0, OP_PASS, 4'd6, 4'd0);
      load(3, OP_PASS, 4'd9, 4'd0);
      exp_q.push_back({2'd3, 6'd9});
      exp_q.push_back({2'd0, 6'd6});
      bus.req_valid = 4'b1001;
      wait_grant(g);
      chk("sparse_first", int'(g), 8);
      bus.req_valid[3] = 1'b0;
      wait_grant(g);
      chk("sparse_second", int'(g), 1);
      bus.req_valid[0] = 1'b0;
      wait_idle();

      // Backpressure with another requester waiting
      bus.rsp_ready = 1'b0;
      send(2, OP_ADD, 4'd1, 4'd2, 6'd3, 1'b1);
      cyc(1);
      load(0, OP_SUB, 4'd7, 4'd3);
      exp_q.push_back({2'd0, 6'd4});
      bus.req_valid[0] = 1'b1;
      for (int k = 0; k < 10; k++) begin
         chk("bp_rsp_valid", int'(bus.rsp_valid), 1);
         chk("bp_rsp_data", int'(bus.rsp_data), 3);
         chk("bp_rsp_id", int'(bus.rsp_id), 2);
         chk("bp_req_ready", int'(bus.req_ready), 0);
         cyc(1);
      end
      bus.rsp_ready = 1'b1;
      cyc(1);
      chk("bp_release_busy", int'(busy), 0);
      chk("bp_release_valid", int'(bus.rsp_valid), 0);
      wait_grant(g);
      chk("bp_next_grant", int'(g), 1);
      bus.req_valid[0] = 1'b0;
      wait_idle();

      // Async reset during EXEC discards the op
      bus.rsp_ready = 1'b0;
      send(1, OP_ADD, 4'd1, 4'd1, 6'd2, 1'b0);
      chk("pre_reset_busy", int'(busy), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rsp_valid", int'(bus.rsp_valid), 0);
      chk("async_busy", int'(busy), 0);
      chk("async_req_ready", int'(bus.req_ready), 0);
      cyc(2);
      rst_n = 1'b1;
      bus.rsp_ready = 1'b1;
      cyc(3);
      chk("no_stale_rsp", int'(bus.rsp_valid), 0);
      chk("no_stale_busy", int'(busy), 0);
      load(0, OP_PASS, 4'd11, 4'd0);
      exp_q.push_back({2'd0, 6'd11});
      bus.req_valid = '1;
      wait_grant(g);
      chk("post_reset_grant", int'(g), 1);
      bus.req_valid = '0;
      wait_idle();

      cyc(2);
      chk("queue_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
